// File: rtl/stack_arbiter.sv
// Arbitrates NREQ requesters onto one shared negedge-clocked stack, one push/pop at a time,
// rejecting overflow/underflow/push+pop. Round-robin when STACK_ARB_RR_EN is defined, else fixed priority.
module stack_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int NREQ  = 2,
  localparam int LW   = $clog2(DEPTH + 1),
  localparam int SW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_push,
  input  logic [NREQ-1:0]       req_pop,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       err,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy,
  output logic [LW-1:0]         level,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [WIDTH-1:0]      stk_din,
  input  logic [WIDTH-1:0]      stk_dout,
  input  logic                  stk_full,
  input  logic                  stk_empty
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] pending;
  logic            any_pend;
  logic [SW-1:0]   sel_c, sel_q;
  logic            win_push, win_pop, rej_c;
  logic [WIDTH-1:0] win_data;
  logic            rej_q, push_q;

  assign pending = req_push | req_pop;

`ifdef STACK_ARB_RR_EN
  logic [SW-1:0] rr_q;

  // Search starts just after the last served requester.
  always_comb begin
    int idx;
    idx      = 0;
    sel_c    = '0;
    any_pend = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!any_pend && pending[idx]) begin
        any_pend = 1'b1;
        sel_c    = SW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_q <= SW'(NREQ - 1);
    else if (state == DONE)
      rr_q <= sel_q;
  end
`else
  // Descending scan so the lowest pending index is the last to overwrite.
  always_comb begin
    sel_c    = '0;
    any_pend = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        any_pend = 1'b1;
        sel_c    = SW'(i);
      end
    end
  end
`endif

  always_comb begin
    win_push = req_push[sel_c];
    win_pop  = req_pop[sel_c];
    win_data = req_data[int'(sel_c)*WIDTH +: WIDTH];
    rej_c    = (win_push & win_pop)
             | (win_push & (stk_full  | (level == LW'(DEPTH))))
             | (win_pop  & (stk_empty | (level == '0)));
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_pend) state_nxt = rej_c ? DONE : ISSUE;
      ISSUE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt      = '0;
    err      = '0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    busy     = 1'b0;
    case (state)
      ISSUE: begin
        busy     = 1'b1;
        stk_push = push_q;
        stk_pop  = ~push_q;
      end
      DONE: begin
        busy       = 1'b1;
        gnt[sel_q] = 1'b1;
        err[sel_q] = rej_q;
      end
      default: ;
    endcase
  end

  // The top word is captured at decision time since the stack pops it on the following negedge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      rej_q    <= 1'b0;
      push_q   <= 1'b0;
      stk_din  <= '0;
      rsp_data <= '0;
      level    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_pend) begin
            sel_q  <= sel_c;
            rej_q  <= rej_c;
            push_q <= win_push;
            if (!rej_c) begin
              if (win_push)
                stk_din <= win_data;
              else
                rsp_data <= stk_dout;
            end
          end
        end
        ISSUE: level <= push_q ? level + LW'(1) : level - LW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a queue-based golden stack checked on every grant.
module tb_stack_arbiter;
  localparam int W = 16;
  localparam int D = 8;
  localparam int N = 2;
  localparam int LW = $clog2(D + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_push, req_pop;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     gnt, err;
  logic [W-1:0]     rsp_data, stk_din, stk_dout;
  logic             busy, stk_push, stk_pop, stk_full, stk_empty;
  logic [LW-1:0]    level;

  always #5 clk = ~clk;

  stack_arbiter #(.WIDTH(W), .DEPTH(D), .NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_push(req_push), .req_pop(req_pop), .req_data(req_data),
    .gnt(gnt), .err(err), .rsp_data(rsp_data), .busy(busy), .level(level),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Shared stack device: acts on negedge, reset by the same rst.
  logic [W-1:0] mem [D];
  int sp = 0;
  always @(negedge clk) begin
    if (rst) sp <= 0;
    else if (stk_push && sp < D) begin mem[sp] <= stk_din; sp <= sp + 1; end
    else if (stk_pop && sp > 0) sp <= sp - 1;
  end
  assign stk_dout  = (sp > 0) ? mem[sp-1] : '0;
  assign stk_full  = (sp == D);
  assign stk_empty = (sp == 0);

  // Golden model: a LIFO queue plus the last popped word.
  logic [W-1:0] gq [$];
  logic [W-1:0] g_rsp = '0;
  int ops = 0;
  int npush_total = 0;

  always @(negedge clk) begin
    int w;
    bit p, q, e;
    if (rst) begin
      gq.delete();
      g_rsp = '0;
      ops = 0;
    end else begin
      chk("push_pop_exclusive", 32'(stk_push & stk_pop), 32'd0);
      chk("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
      chk("err_outside_gnt", 32'(err & ~gnt), 32'd0);
      if (stk_push || stk_pop) ops++;
      if (stk_push) npush_total++;
      if (gnt != '0) begin
        w = 0;
        for (int i = 0; i < N; i++) if (gnt[i]) w = i;
        p = req_push[w];
        q = req_pop[w];
        e = (p && q) || (p && gq.size() == D) || (q && gq.size() == 0);
        chk("err", 32'(err[w]), 32'(e));
        chk("stack_ops", 32'(ops), e ? 32'd0 : 32'd1);
        if (!e) begin
          if (p) gq.push_back(req_data[w*W +: W]);
          else   g_rsp = gq.pop_back();
        end
        chk("level", 32'(level), 32'(gq.size()));
        chk("rsp_data", 32'(rsp_data), 32'(g_rsp));
        ops = 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req_push = '0;
    req_pop  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One request from requester r; returns err, grant latency in cycles, and busy cycles seen.
  task automatic op(input int r, input bit p, input bit q, input logic [W-1:0] d,
                    output bit e, output int lat, output int bc);
    bit got;
    @(posedge clk);
    #1;
    req_push[r] = p;
    req_pop[r]  = q;
    req_data[r*W +: W] = d;
    got = 1'b0;
    lat = 0;
    bc  = 0;
    while (!got && lat < 50) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      got = gnt[r];
    end
    chk("gnt_seen", 32'(got), 32'd1);
    e = err[r];
    @(posedge clk);
    #1;
    req_push[r] = 1'b0;
    req_pop[r]  = 1'b0;
  endtask

  initial begin
    bit e;
    int lat, bc, n0, winner, seen;
    int exp_order [4];
`ifdef STACK_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    req_data = '0;
    do_reset();

    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stk_push", 32'(stk_push), 32'd0);
    chk("rst_stk_pop", 32'(stk_pop), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp", 32'(rsp_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);

    // 1: single push, accepted latency
    n0 = npush_total;
    op(0, 1, 0, 16'hA5A5, e, lat, bc);
    chk("t1_err", 32'(e), 32'd0);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_busy_cycles", 32'(bc), 32'd2);
    chk("t1_push_pulses", 32'(npush_total - n0), 32'd1);
    chk("t1_level", 32'(level), 32'd1);

    // 2: fill to DEPTH from requester 1, then overflow
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      op(1, 1, 0, 16'(i), e, lat, bc);
      chk("t2_fill_err", 32'(e), 32'd0);
    end
    chk("t2_full_level", 32'(level), 32'd8);
    n0 = npush_total;
    op(1, 1, 0, 16'h0009, e, lat, bc);
    chk("t2_ovf_err", 32'(e), 32'd1);
    chk("t2_ovf_latency", 32'(lat), 32'd2);
    chk("t2_ovf_busy_cycles", 32'(bc), 32'd1);
    chk("t2_ovf_no_push", 32'(npush_total - n0), 32'd0);
    chk("t2_ovf_level", 32'(level), 32'd8);

    // 3: drain in LIFO order, underflow keeps rsp_data, then push/pop round trip
    for (int i = 1; i <= 8; i++) begin
      op(0, 0, 1, '0, e, lat, bc);
      chk("t3_drain_rsp", 32'(rsp_data), 32'(9 - i));
    end
    op(0, 0, 1, '0, e, lat, bc);
    chk("t3_udf_err", 32'(e), 32'd1);
    chk("t3_udf_latency", 32'(lat), 32'd2);
    chk("t3_udf_rsp_kept", 32'(rsp_data), 32'h0001);
    op(0, 1, 0, 16'h1234, e, lat, bc);
    op(0, 0, 1, '0, e, lat, bc);
    chk("t3_pop_rsp", 32'(rsp_data), 32'h1234);
    chk("t3_pop_level", 32'(level), 32'd0);

    // 4: both requesters pushing continuously
    do_reset();
    @(posedge clk);
    #1;
    req_data = {16'hBBBB, 16'hAAAA};
    req_push = 2'b11;
    for (int g = 0; g < 4; g++) begin
      seen = 0;
      winner = -1;
      while (seen < 20 && winner < 0) begin
        @(negedge clk);
        seen++;
        if (gnt[0]) winner = 0;
        else if (gnt[1]) winner = 1;
      end
      chk("t4_grant_order", 32'(winner), 32'(exp_order[g]));
    end
    @(posedge clk);
    #1 req_push = '0;
    @(negedge clk);
    chk("t4_level", 32'(level), 32'd4);

    // 5: push and pop together from one requester
    op(1, 1, 1, 16'hDEAD, e, lat, bc);
    chk("t5_err", 32'(e), 32'd1);
    chk("t5_latency", 32'(lat), 32'd2);
    chk("t5_level", 32'(level), 32'd4);

    // 6: reset during ISSUE aborts the operation
    do_reset();
    @(posedge clk);
    #1;
    req_data[W-1:0] = 16'h7777;
    req_push[0] = 1'b1;
    seen = 0;
    while (seen < 10 && !stk_push) begin
      @(negedge clk);
      seen++;
    end
    chk("t6_issue_reached", 32'(stk_push), 32'd1);
    #1;
    rst = 1'b1;
    req_push = '0;
    @(negedge clk);
    chk("t6_gnt", 32'(gnt), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_stk_push", 32'(stk_push), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_rsp", 32'(rsp_data), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (gnt != '0 || busy) seen++;
    end
    chk("t6_quiet_after_abort", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
